// File: rtl/csr_access_arb_pkg.sv
// Shared widths, CSR op encodings and FSM state type for the CSR access arbiter.
package csr_access_arb_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned CSR_IDX_WIDTH = 12;

    typedef enum logic [1:0] {
        CSR_OP_RD = 2'b00,
        CSR_OP_RW = 2'b01,
        CSR_OP_RS = 2'b10,
        CSR_OP_RC = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_e;

endpackage

// File: rtl/csr_rmw_alu.sv
// Read-modify-write value for a CSR access: RW replaces, RS sets bits, RC clears bits.
module csr_rmw_alu
    import csr_access_arb_pkg::*;
(
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rdata,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_wdata
);

    always_comb begin
        o_wdata = i_rdata;
        case (csr_op_e'(i_op))
            CSR_OP_RW: o_wdata = i_wdata;
            CSR_OP_RS: o_wdata = i_rdata | i_wdata;
            CSR_OP_RC: o_wdata = i_rdata & ~i_wdata;
            default:   o_wdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/csr_access_arb.sv
// Arbitrates the CSR file port between core and debug, sequencing each access as
// read, optional write-back, then a held response to the owning requester.
module csr_access_arb
    import csr_access_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     core_req_valid,
    output logic                     core_req_ready,
    input  logic [1:0]               core_req_op,
    input  logic [CSR_IDX_WIDTH-1:0] core_req_idx,
    input  logic [XLEN-1:0]          core_req_wdata,
    output logic                     core_rsp_valid,
    input  logic                     core_rsp_ready,
    output logic [XLEN-1:0]          core_rsp_rdata,
    output logic                     core_rsp_ilgl,

    input  logic                     dbg_req_valid,
    output logic                     dbg_req_ready,
    input  logic [1:0]               dbg_req_op,
    input  logic [CSR_IDX_WIDTH-1:0] dbg_req_idx,
    input  logic [XLEN-1:0]          dbg_req_wdata,
    output logic                     dbg_rsp_valid,
    input  logic                     dbg_rsp_ready,
    output logic [XLEN-1:0]          dbg_rsp_rdata,
    output logic                     dbg_rsp_ilgl,

    output logic                     csr_rd_en,
    output logic                     csr_wr_en,
    output logic [CSR_IDX_WIDTH-1:0] csr_idx,
    output logic [XLEN-1:0]          csr_cmd_wdata,
    input  logic [XLEN-1:0]          csr_cmd_rdata,
    input  logic                     csr_access_ilgl
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    arb_state_e          r_state;
    csr_op_e             r_op;
    logic [XLEN-1:0]     r_wdata;
    logic [XLEN-1:0]     r_rdata;
    logic                r_ilgl;
    logic                r_owner_dbg;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_idle;
    logic                w_core_win;
    logic                w_core_gnt;
    logic                w_dbg_gnt;
    logic                w_rsp_hs;
    logic                w_rsp_ilgl;
    logic [XLEN-1:0]     w_rsp_rdata;
    logic [XLEN-1:0]     w_alu_wdata;

    // Ready is gated by rst_n so both requesters see ready=0 while reset is held.
    assign w_idle     = (r_state == ST_IDLE) && rst_n;
    assign w_core_win = core_req_valid && (!dbg_req_valid || (r_cnt == LIM));
    assign w_core_gnt = w_idle && w_core_win;
    assign w_dbg_gnt  = w_idle && dbg_req_valid && !w_core_win;

    assign core_req_ready = w_core_gnt;
    assign dbg_req_ready  = w_dbg_gnt;

    assign w_rsp_hs = r_owner_dbg ? (dbg_rsp_valid && dbg_rsp_ready)
                                  : (core_rsp_valid && core_rsp_ready);

    // Response can be launched from READ (live file data) or WRITE (captured data).
    assign w_rsp_ilgl  = (r_state == ST_READ) ? csr_access_ilgl : r_ilgl;
    assign w_rsp_rdata = w_rsp_ilgl ? '0 :
                         ((r_state == ST_READ) ? csr_cmd_rdata : r_rdata);

    csr_rmw_alu u_rmw_alu (
        .i_op    (r_op),
        .i_rdata (csr_cmd_rdata),
        .i_wdata (r_wdata),
        .o_wdata (w_alu_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_op           <= CSR_OP_RD;
            r_wdata        <= '0;
            r_rdata        <= '0;
            r_ilgl         <= 1'b0;
            r_owner_dbg    <= 1'b0;
            r_cnt          <= '0;
            csr_rd_en      <= 1'b0;
            csr_wr_en      <= 1'b0;
            csr_idx        <= '0;
            csr_cmd_wdata  <= '0;
            core_rsp_valid <= 1'b0;
            core_rsp_rdata <= '0;
            core_rsp_ilgl  <= 1'b0;
            dbg_rsp_valid  <= 1'b0;
            dbg_rsp_rdata  <= '0;
            dbg_rsp_ilgl   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_core_gnt || w_dbg_gnt) begin
                        r_op        <= csr_op_e'(w_dbg_gnt ? dbg_req_op : core_req_op);
                        csr_idx     <= w_dbg_gnt ? dbg_req_idx : core_req_idx;
                        r_wdata     <= w_dbg_gnt ? dbg_req_wdata : core_req_wdata;
                        r_owner_dbg <= w_dbg_gnt;
                        csr_rd_en   <= 1'b1;
                        r_state     <= ST_READ;
                    end
                    if (w_core_gnt) begin
                        r_cnt <= '0;
                    end else if (w_dbg_gnt && core_req_valid && (r_cnt != LIM)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_READ: begin
                    csr_rd_en <= 1'b0;
                    r_rdata   <= csr_cmd_rdata;
                    r_ilgl    <= csr_access_ilgl;
                    if (csr_access_ilgl || (r_op == CSR_OP_RD)) begin
                        core_rsp_valid <= !r_owner_dbg;
                        core_rsp_rdata <= r_owner_dbg ? '0 : w_rsp_rdata;
                        core_rsp_ilgl  <= !r_owner_dbg && w_rsp_ilgl;
                        dbg_rsp_valid  <= r_owner_dbg;
                        dbg_rsp_rdata  <= r_owner_dbg ? w_rsp_rdata : '0;
                        dbg_rsp_ilgl   <= r_owner_dbg && w_rsp_ilgl;
                        r_state        <= ST_RESP;
                    end else begin
                        csr_wr_en     <= 1'b1;
                        csr_cmd_wdata <= w_alu_wdata;
                        r_state       <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    csr_wr_en      <= 1'b0;
                    csr_cmd_wdata  <= '0;
                    core_rsp_valid <= !r_owner_dbg;
                    core_rsp_rdata <= r_owner_dbg ? '0 : w_rsp_rdata;
                    core_rsp_ilgl  <= !r_owner_dbg && w_rsp_ilgl;
                    dbg_rsp_valid  <= r_owner_dbg;
                    dbg_rsp_rdata  <= r_owner_dbg ? w_rsp_rdata : '0;
                    dbg_rsp_ilgl   <= r_owner_dbg && w_rsp_ilgl;
                    r_state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        core_rsp_valid <= 1'b0;
                        core_rsp_rdata <= '0;
                        core_rsp_ilgl  <= 1'b0;
                        dbg_rsp_valid  <= 1'b0;
                        dbg_rsp_rdata  <= '0;
                        dbg_rsp_ilgl   <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_arb.sv
// Self-checking bench: behavioural CSR file plus a transaction-level reference model.
module tb_csr_access_arb;
    import csr_access_arb_pkg::*;

    localparam int unsigned LIM = 4;

    logic        clk;
    logic        rst_n;
    logic        core_req_valid, core_req_ready, core_rsp_valid, core_rsp_ready, core_rsp_ilgl;
    logic [1:0]  core_req_op;
    logic [11:0] core_req_idx;
    logic [31:0] core_req_wdata, core_rsp_rdata;
    logic        dbg_req_valid, dbg_req_ready, dbg_rsp_valid, dbg_rsp_ready, dbg_rsp_ilgl;
    logic [1:0]  dbg_req_op;
    logic [11:0] dbg_req_idx;
    logic [31:0] dbg_req_wdata, dbg_rsp_rdata;
    logic        csr_rd_en, csr_wr_en, csr_access_ilgl;
    logic [11:0] csr_idx;
    logic [31:0] csr_cmd_wdata, csr_cmd_rdata;

    logic [31:0] csr_mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    int unsigned ref_cnt;
    int unsigned n_err, n_chk, viol;
    logic        prev_rd_il;

    csr_access_arb #(.STARVE_LIM(LIM), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_op(core_req_op), .core_req_idx(core_req_idx), .core_req_wdata(core_req_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
        .core_rsp_rdata(core_rsp_rdata), .core_rsp_ilgl(core_rsp_ilgl),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_op(dbg_req_op), .dbg_req_idx(dbg_req_idx), .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
        .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_ilgl(dbg_rsp_ilgl),
        .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_idx(csr_idx),
        .csr_cmd_wdata(csr_cmd_wdata), .csr_cmd_rdata(csr_cmd_rdata),
        .csr_access_ilgl(csr_access_ilgl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_ilgl(input logic [11:0] idx);
        return (idx[11:8] == 4'hA) || (idx == 12'h7FF);
    endfunction

    assign csr_cmd_rdata   = csr_mem[csr_idx];
    assign csr_access_ilgl = is_ilgl(csr_idx);

    always @(posedge clk) begin
        if (csr_wr_en) csr_mem[csr_idx] <= csr_cmd_wdata;
    end

    // Protocol monitor: never read and write together, never write after an illegal read.
    always @(negedge clk) begin
        prev_rd_il <= csr_rd_en && csr_access_ilgl;
        if ((csr_rd_en && csr_wr_en) || (csr_wr_en && prev_rd_il)) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rmw(input logic [1:0] op, input logic [31:0] old, input logic [31:0] wd);
        case (op)
            2'b01:   return wd;
            2'b10:   return old | wd;
            2'b11:   return old & ~wd;
            default: return old;
        endcase
    endfunction

    task automatic run_txn(input bit dbg, input logic [1:0] op, input logic [11:0] idx,
                           input logic [31:0] wd, input int unsigned stall);
        logic [31:0] old, nv, seen_wd, hold_rd;
        bit il, wr_exp, seen_wr, got;
        int unsigned lat;
        il      = is_ilgl(idx);
        old     = ref_mem[idx];
        wr_exp  = !il && (op != 2'b00);
        nv      = rmw(op, old, wd);
        seen_wr = 0; seen_wd = '0; got = 0; lat = 0;
        @(negedge clk);
        if (dbg) begin
            dbg_req_valid = 1; dbg_req_op = op; dbg_req_idx = idx; dbg_req_wdata = wd;
        end else begin
            core_req_valid = 1; core_req_op = op; core_req_idx = idx; core_req_wdata = wd;
        end
        #1;
        chk("winner_ready", {31'b0, dbg ? dbg_req_ready : core_req_ready}, 32'd1);
        chk("loser_ready",  {31'b0, dbg ? core_req_ready : dbg_req_ready}, 32'd0);
        if (!dbg) ref_cnt = 0;
        @(posedge clk); #1;
        core_req_valid = 0; dbg_req_valid = 0;
        for (int unsigned c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("read_strobe", {31'b0, csr_rd_en}, 32'd1);
                chk("read_idx", {20'b0, csr_idx}, {20'b0, idx});
            end
            if (csr_wr_en) begin
                seen_wr = 1; seen_wd = csr_cmd_wdata;
            end
            if (dbg ? dbg_rsp_valid : core_rsp_valid) begin
                got = 1; lat = c;
            end
        end
        chk("rsp_seen", {31'b0, got}, 32'd1);
        chk("rsp_latency", lat, wr_exp ? 32'd3 : 32'd2);
        chk("write_issued", {31'b0, seen_wr}, {31'b0, wr_exp});
        if (wr_exp) chk("write_data", seen_wd, nv);
        chk("rsp_rdata", dbg ? dbg_rsp_rdata : core_rsp_rdata, il ? 32'd0 : old);
        chk("rsp_ilgl", {31'b0, dbg ? dbg_rsp_ilgl : core_rsp_ilgl}, {31'b0, il});
        chk("nonowner_quiet", {30'b0, dbg ? core_rsp_valid : dbg_rsp_valid,
                               (dbg ? core_rsp_rdata : dbg_rsp_rdata) != 32'd0}, 32'd0);
        hold_rd = il ? 32'd0 : old;
        for (int unsigned s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, dbg ? dbg_rsp_valid : core_rsp_valid}, 32'd1);
            chk("stall_rdata", dbg ? dbg_rsp_rdata : core_rsp_rdata, hold_rd);
        end
        if (dbg) dbg_rsp_ready = 1; else core_rsp_ready = 1;
        @(posedge clk); #1;
        dbg_rsp_ready = 0; core_rsp_ready = 0;
        chk("rsp_dropped", {30'b0, core_rsp_valid, dbg_rsp_valid}, 32'd0);
        if (wr_exp) ref_mem[idx] = nv;
        chk("csr_contents", csr_mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [11:0] pool [0:7];
        int unsigned grants, cyc;
        bit exp_core;
        n_err = 0; n_chk = 0; viol = 0; ref_cnt = 0; prev_rd_il = 0;
        for (int unsigned i = 0; i < 4096; i++) csr_mem[i] = (i * 32'h0101_0107) ^ 32'h5A5A_0000;
        csr_mem[12'h300] = 32'h0000_0008;
        csr_mem[12'h341] = 32'hFFFF_FFFF;
        for (int unsigned i = 0; i < 4096; i++) ref_mem[i] = csr_mem[i];
        rst_n = 0;
        core_req_valid = 0; core_req_op = 0; core_req_idx = 0; core_req_wdata = 0; core_rsp_ready = 0;
        dbg_req_valid = 0; dbg_req_op = 0; dbg_req_idx = 0; dbg_req_wdata = 0; dbg_rsp_ready = 0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {26'b0, core_req_ready, dbg_req_ready, core_rsp_valid, dbg_rsp_valid,
                           csr_rd_en, csr_wr_en}, 32'd0);
        chk("reset_idx", {20'b0, csr_idx}, 32'd0);
        chk("reset_wdata", csr_cmd_wdata, 32'd0);
        chk("reset_rsp", core_rsp_rdata | dbg_rsp_rdata, 32'd0);
        rst_n = 1;
        @(negedge clk);
        chk("idle_no_req", {30'b0, core_req_ready, dbg_req_ready}, 32'd0);

        run_txn(0, 2'b10, 12'h300, 32'h0000_0080, 0);
        chk("rs_result", csr_mem[12'h300], 32'h0000_0088);
        run_txn(1, 2'b11, 12'h341, 32'h0000_000F, 1);
        chk("rc_result", csr_mem[12'h341], 32'hFFFF_FFF0);
        run_txn(0, 2'b00, 12'hF14, 32'hDEAD_BEEF, 0);
        run_txn(0, 2'b01, 12'hA05, 32'h1234_5678, 0);
        run_txn(1, 2'b01, 12'h7FF, 32'h0000_0001, 5);

        // Both requesters valid continuously with read-only accesses.
        @(negedge clk);
        core_req_valid = 1; core_req_op = 2'b00; core_req_idx = 12'h300;
        dbg_req_valid  = 1; dbg_req_op  = 2'b00; dbg_req_idx  = 12'h341;
        core_rsp_ready = 1; dbg_rsp_ready = 1;
        grants = 0; cyc = 0;
        while (grants < 7 && cyc < 80) begin
            #1;
            if (core_req_ready || dbg_req_ready) begin
                exp_core = (ref_cnt == LIM);
                chk("single_grant", {31'b0, core_req_ready && dbg_req_ready}, 32'd0);
                chk("starve_winner", {31'b0, core_req_ready}, {31'b0, exp_core});
                if (exp_core) ref_cnt = 0;
                else if (ref_cnt < LIM) ref_cnt++;
                grants++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("starve_grants_seen", grants, 32'd7);
        core_req_valid = 0; dbg_req_valid = 0;
        repeat (4) @(negedge clk);
        core_rsp_ready = 0; dbg_rsp_ready = 0;

        pool[0] = 12'h300; pool[1] = 12'h301; pool[2] = 12'h341; pool[3] = 12'h342;
        pool[4] = 12'hA10; pool[5] = 12'h7FF; pool[6] = 12'h305; pool[7] = 12'hB00;
        for (int unsigned t = 0; t < 24; t++) begin
            run_txn(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pool[$urandom_range(0, 7)],
                    $urandom, $urandom_range(0, 2));
        end

        // Reset while a write-back is on the bus.
        @(negedge clk);
        core_req_valid = 1; core_req_op = 2'b01; core_req_idx = 12'h305; core_req_wdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        core_req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_write", {31'b0, csr_wr_en}, 32'd1);
        rst_n = 0;
        #1;
        chk("async_reset_ctrl", {26'b0, core_req_ready, dbg_req_ready, core_rsp_valid, dbg_rsp_valid,
                                 csr_rd_en, csr_wr_en}, 32'd0);
        chk("async_reset_data", {20'b0, csr_idx} | csr_cmd_wdata | core_rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1;
        ref_cnt = 0;
        cyc = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            @(negedge clk);
            if (csr_wr_en || csr_rd_en || core_rsp_valid || dbg_rsp_valid) cyc++;
        end
        chk("post_reset_quiet", cyc, 32'd0);
        chk("aborted_no_write", csr_mem[12'h305], ref_mem[12'h305]);
        run_txn(0, 2'b00, 12'h305, 32'h0, 0);

        chk("protocol_monitor", viol, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
